// File: rtl/rom_stream_ctl_pkg.sv
// rom_stream_ctl_pkg
//   State encoding and width helpers shared by rom_stream_ctl and gap_timer.
//   No ports; imported with "import rom_stream_ctl_pkg::*".
package rom_stream_ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REWIND = 3'd1,
    ST_FETCH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_SEND   = 3'd4,
    ST_GAP    = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Bits needed to hold values 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rom_stream_ctl_gap_timer.sv
// gap_timer
//   Down-counter that times the idle gap after each accepted word.
//   load is pulsed on the accept edge and presets the count to GAP; while run
//   is high the count decrements and expire is raised on the last gap cycle
//   (terminal count of one), so the owner spends exactly GAP cycles waiting.
// Ports
//   clock   in   single clock, posedge
//   reset   in   synchronous active-high, clears the count
//   load    in   preset the count to GAP
//   run     in   owner is in its gap state; count down
//   expire  out  last gap cycle
module gap_timer
  import rom_stream_ctl_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = cnt_width(GAP);
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = run && (cnt_q == ONE);

endmodule

// File: rtl/rom_stream_ctl.sv
// rom_stream_ctl
//   Drains a sequential ROM source (get/out/empty) into a valid/ready sink.
//   Each start rewinds the source, then words are fetched one at a time,
//   registered and held until the sink accepts. An optional GAP of idle
//   cycles follows each accept. done pulses once the source runs empty.
//   Build option ROM_STREAM_REPEAT_EN: replay the whole message LOOPS times
//   per start before done; undefined gives a single pass.
// Ports
//   clock      in   single clock, posedge
//   reset      in   synchronous active-high
//   start      in   begin a pass, honoured only in IDLE
//   busy       out  high in every state except IDLE
//   done       out  one-cycle completion pulse
//   src_reset  out  rewinds the source (reset or REWIND state)
//   src_get    out  fetch strobe, only in FETCH with source not empty
//   src_data   in   source word, valid the cycle after src_get
//   src_empty  in   source exhausted
//   m_valid    out  sink word available
//   m_data     out  registered sink word
//   m_ready    in   sink accepts when m_valid && m_ready
//
// state  | meaning
// IDLE   | waiting for start
// REWIND | src_reset high for one cycle
// FETCH  | done with source if empty, else strobe src_get
// LOAD   | capture src_data into m_data, raise m_valid
// SEND   | hold word until the sink accepts
// GAP    | idle GAP cycles after an accept
// DONE   | one-cycle done pulse
module rom_stream_ctl
  import rom_stream_ctl_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned GAP   = 0,
  parameter int unsigned LOOPS = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         src_reset,
  output logic         src_get,
  input  logic [W-1:0] src_data,
  input  logic         src_empty,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);

  state_e        state_q, state_d;
  logic          m_valid_q, m_valid_d;
  logic [W-1:0]  m_data_q, m_data_d;
  logic          gap_expire;

`ifdef ROM_STREAM_REPEAT_EN
  localparam int unsigned PW = cnt_width(LOOPS - 1);
  localparam logic [PW-1:0] LAST_PASS = PW'(LOOPS - 1);
  logic [PW-1:0] pass_q, pass_d;
`endif

  generate
    if (GAP > 0) begin : g_gap
      gap_timer #(.GAP(GAP)) u_gap_timer (
        .clock  (clock),
        .reset  (reset),
        .load   ((state_q == ST_SEND) && m_ready),
        .run    (state_q == ST_GAP),
        .expire (gap_expire)
      );
    end else begin : g_no_gap
      assign gap_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    src_get   = 1'b0;
    done      = 1'b0;
`ifdef ROM_STREAM_REPEAT_EN
    pass_d    = pass_q;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef ROM_STREAM_REPEAT_EN
        pass_d = '0;
`endif
        if (start) state_d = ST_REWIND;
      end
      ST_REWIND: state_d = ST_FETCH;
      ST_FETCH: begin
        if (src_empty) begin
`ifdef ROM_STREAM_REPEAT_EN
          if (pass_q < LAST_PASS) begin
            pass_d  = pass_q + PW'(1);
            state_d = ST_REWIND;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          src_get = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        m_data_d  = src_data;
        m_valid_d = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = (GAP > 0) ? ST_GAP : ST_FETCH;
        end
      end
      ST_GAP: begin
        if (gap_expire) state_d = ST_FETCH;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`ifdef ROM_STREAM_REPEAT_EN
      pass_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`ifdef ROM_STREAM_REPEAT_EN
      pass_q    <= pass_d;
`endif
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign src_reset = reset | (state_q == ST_REWIND);
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;

endmodule

// File: tb/tb_rom_stream_ctl.sv
// tb_rom_stream_ctl
//   Directed bench for rom_stream_ctl. Two DUTs share the clock: u_dut0 with
//   GAP=0 and u_dut1 with GAP=3. Each has its own sequential ROM model
//   (rewind / get / empty, data one cycle after get) holding "Hello!\n".
//   Timing is measured as rel = posedges since the edge that sampled start,
//   so rel=n is the cycle following edge n. With GAP=0 and m_ready=1:
//   REWIND rel0, FETCH rel1, LOAD rel2, first SEND rel3, then 3 cycles per
//   word; the empty FETCH lands at rel22 and DONE at rel23. A repeat pass
//   adds another 23 cycles.
module tb_rom_stream_ctl;

`ifdef ROM_STREAM_REPEAT_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif
  localparam int NW = 7 * PASSES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset_v, start_v, m_ready_v;
  logic             busy0, busy1, done0, done1, srst0, srst1, get0, get1;
  logic             mv0, mv1;
  logic [7:0]       md0, md1;
  logic [1:0]       busy_v, done_v, src_reset_v, src_get_v, m_valid_v, src_empty_v;
  logic [1:0][7:0]  m_data_v, src_data_v;

  logic [7:0] msg [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h0A};
  int rom_addr [2];
  int rom_size [2];

  rom_stream_ctl #(.W(8), .GAP(0), .LOOPS(2)) u_dut0 (
    .clock(clk), .reset(reset_v[0]), .start(start_v[0]), .busy(busy0), .done(done0),
    .src_reset(srst0), .src_get(get0), .src_data(src_data_v[0]), .src_empty(src_empty_v[0]),
    .m_valid(mv0), .m_data(md0), .m_ready(m_ready_v[0]));

  rom_stream_ctl #(.W(8), .GAP(3), .LOOPS(2)) u_dut1 (
    .clock(clk), .reset(reset_v[1]), .start(start_v[1]), .busy(busy1), .done(done1),
    .src_reset(srst1), .src_get(get1), .src_data(src_data_v[1]), .src_empty(src_empty_v[1]),
    .m_valid(mv1), .m_data(md1), .m_ready(m_ready_v[1]));

  assign busy_v      = {busy1, busy0};
  assign done_v      = {done1, done0};
  assign src_reset_v = {srst1, srst0};
  assign src_get_v   = {get1, get0};
  assign m_valid_v   = {mv1, mv0};
  assign m_data_v    = {md1, md0};
  assign src_empty_v = {(rom_addr[1] >= rom_size[1]), (rom_addr[0] >= rom_size[0])};

  // ROM models
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (src_reset_v[d]) begin
        rom_addr[d] <= 0;
      end else if (src_get_v[d] && (rom_addr[d] < rom_size[d])) begin
        src_data_v[d] <= msg[rom_addr[d]];
        rom_addr[d]   <= rom_addr[d] + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Observation of the selected DUT
  int         sel = 0;
  int         t0 = 0;
  int         first_v = -1;
  int         done_n = 0;
  int         done_t = -1;
  logic [7:0] words[$];
  int         acc_t[$];
  int         get_t[$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (src_get_v[d]) chk("get_while_empty", {31'd0, src_empty_v[d]}, 32'd0);
    if (m_valid_v[sel] && m_ready_v[sel]) begin
      words.push_back(m_data_v[sel]);
      acc_t.push_back(cyc - t0);
    end
    if (m_valid_v[sel] && (first_v < 0)) first_v = cyc - t0;
    if (done_v[sel]) begin
      done_n++;
      done_t = cyc - t0;
    end
    if (src_get_v[sel]) get_t.push_back(cyc - t0);
  end

  task automatic clear_obs();
    first_v = -1;
    done_n  = 0;
    done_t  = -1;
    words.delete();
    acc_t.delete();
    get_t.delete();
  endtask

  task automatic start_pass(input int d);
    @(posedge clk); #1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    start_v[d] = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_n > 0) break;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_n, 1);
  endtask

  task automatic check_words(input string tag, input int n);
    chk({tag, "_count"}, words.size(), n);
    for (int k = 0; k < n && k < words.size(); k++)
      chk({tag, "_data"}, {24'd0, words[k]}, {24'd0, msg[k % 7]});
  endtask

  initial begin
    int found;
    reset_v   = 2'b11;
    start_v   = 2'b00;
    m_ready_v = 2'b11;
    rom_size[0] = 7;
    rom_size[1] = 7;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",   {31'd0, busy_v[d]},      32'd0);
      chk("rst_done",   {31'd0, done_v[d]},      32'd0);
      chk("rst_get",    {31'd0, src_get_v[d]},   32'd0);
      chk("rst_valid",  {31'd0, m_valid_v[d]},   32'd0);
      chk("rst_data",   {24'd0, m_data_v[d]},    32'd0);
      chk("rst_srcrst", {31'd0, src_reset_v[d]}, 32'd1);
    end
    reset_v = 2'b00;

    // basic stream, GAP=0, sink always ready
    sel = 0;
    clear_obs();
    start_pass(0);
    chk("start_rewind", {31'd0, src_reset_v[0]}, 32'd1);
    wait_done(200);
    chk("first_valid_t", first_v, 3);
    chk("done_t", done_t, 23 * PASSES);
    check_words("basic", NW);
    chk("basic_period", acc_t[1] - acc_t[0], 3);
    chk("basic_refetch", get_t[1] - acc_t[0], 1);
    chk("basic_idle", {31'd0, busy_v[0]}, 32'd0);

    // sink stalls for 5 cycles on the third word (6C)
    clear_obs();
    start_pass(0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid_v[0] && (words.size() == 2)) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stall_found", found, 1);
    m_ready_v[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, m_valid_v[0]}, 32'd1);
      chk("stall_data",  {24'd0, m_data_v[0]}, 32'h6C);
      chk("stall_noget", {31'd0, src_get_v[0]}, 32'd0);
    end
    m_ready_v[0] = 1'b1;
    wait_done(200);
    check_words("stall", NW);

    // start pulses mid-pass are ignored; a later start replays
    clear_obs();
    start_pass(0);
    while (cyc - t0 < 5) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    while (cyc - t0 < 9) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(200);
    repeat (10) @(posedge clk);
    #1;
    chk("ignored_done_count", done_n, 1);
    chk("ignored_idle", {31'd0, busy_v[0]}, 32'd0);
    check_words("ignored", NW);
    clear_obs();
    start_pass(0);
    chk("restart_rewind", {31'd0, src_reset_v[0]}, 32'd1);
    wait_done(200);
    check_words("restart", NW);

    // reset while the fourth word is in SEND
    clear_obs();
    start_pass(0);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_valid_v[0] && (words.size() == 3)) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("rst_mid_found", found, 1);
    chk("rst_mid_word4", {24'd0, m_data_v[0]}, 32'h6C);
    reset_v[0] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid",  {31'd0, m_valid_v[0]},   32'd0);
    chk("rst_mid_busy",   {31'd0, busy_v[0]},      32'd0);
    chk("rst_mid_srcrst", {31'd0, src_reset_v[0]}, 32'd1);
    reset_v[0] = 1'b0;
    clear_obs();
    start_pass(0);
    wait_done(200);
    check_words("after_rst", NW);

    // GAP=3 instance
    sel = 1;
    clear_obs();
    start_pass(1);
    wait_done(400);
    check_words("gap", NW);
    chk("gap_first_valid_t", first_v, 3);
    chk("gap_period", acc_t[1] - acc_t[0], 6);
    for (int k = 0; k < 6; k++)
      chk("gap_idle", get_t[k + 1] - acc_t[k], 4);

    // empty source
    sel = 0;
    rom_size[0] = 0;
    clear_obs();
    start_pass(0);
    wait_done(100);
    chk("empty_no_valid", first_v, -1);
    chk("empty_words", words.size(), 0);
    chk("empty_no_get", get_t.size(), 0);
    chk("empty_done_t", done_t, 2 * PASSES);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
